// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared state encoding and constants for the PC sequencer
package pc_seq_pkg;

   typedef enum logic [1:0] {IDLE, RUN, STALL, ERROR} state_t;

   localparam logic [31:0] PC_INCR = 32'd4;
   localparam int DEFAULT_STALL_TIMEOUT = 255;

endpackage

// File: rtl/pc_target_calc.sv
// pc_target_calc: combinational next-PC selection (sequential, jump, taken branch)
module pc_target_calc
   import pc_seq_pkg::*;
#(
   parameter int OFFSET_W = 8
) (
   input  logic [31:0]         pc_i,
   input  logic [OFFSET_W-1:0] offset_i,
   input  logic                jump_i,
   input  logic                branch_i,
   input  logic                zero_i,
   output logic [31:0]         next_pc_o
);

   logic [31:0] seq_pc;
   logic [31:0] target_pc;

   // Offset counts instruction words relative to PC+4; all sums wrap modulo 2^32
   always_comb begin
      seq_pc    = pc_i + PC_INCR;
      target_pc = seq_pc + ({{(32-OFFSET_W){offset_i[OFFSET_W-1]}}, offset_i} << 2);
      next_pc_o = (jump_i | (branch_i & zero_i)) ? target_pc : seq_pc;
   end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: PC register with busywait freeze, branch/jump select and stall watchdog
module pc_sequencer
   import pc_seq_pkg::*;
#(
   parameter logic [31:0] RESET_PC      = 32'h0000_0000,
   parameter int          OFFSET_W      = 8,
   parameter int          STALL_TIMEOUT = DEFAULT_STALL_TIMEOUT
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                imem_busywait_i,
   input  logic                dmem_busywait_i,
   input  logic                jump_i,
   input  logic                branch_i,
   input  logic                zero_i,
   input  logic [OFFSET_W-1:0] offset_i,
   output logic [31:0]         pc_o,
   output logic                pc_valid_o,
   output logic                stalled_o,
   output logic                timeout_err_o
);

   localparam logic [7:0] TIMEOUT = 8'(STALL_TIMEOUT);

   state_t      state_q;
   logic        rel_q;
   logic [31:0] pc_q;
   logic [7:0]  cnt_q;
   logic        valid_q;
   logic        stalled_q;
   logic        err_q;
   logic [31:0] next_pc_d;
   logic        busy;

   assign busy = imem_busywait_i | dmem_busywait_i;

   pc_target_calc #(.OFFSET_W(OFFSET_W)) u_calc (
      .pc_i      (pc_q),
      .offset_i  (offset_i),
      .jump_i    (jump_i),
      .branch_i  (branch_i),
      .zero_i    (zero_i),
      .next_pc_o (next_pc_d)
   );

   // Reset release stage: rel_q is the first synchroniser flop, the IDLE state register the second
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rel_q <= 1'b0;
      end else begin
         rel_q <= 1'b1;
      end
   end

   // Sequencer FSM with registered outputs; busy freezes the PC and defers the branch decision
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         pc_q      <= RESET_PC;
         cnt_q     <= 8'd0;
         valid_q   <= 1'b0;
         stalled_q <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (rel_q) begin
                  state_q <= RUN;
                  valid_q <= 1'b1;
               end
            end
            RUN: begin
               if (busy) begin
                  state_q   <= STALL;
                  stalled_q <= 1'b1;
                  cnt_q     <= 8'd1;
               end else begin
                  pc_q <= next_pc_d;
               end
            end
            STALL: begin
               if (!busy) begin
                  state_q   <= RUN;
                  stalled_q <= 1'b0;
                  cnt_q     <= 8'd0;
                  pc_q      <= next_pc_d;
               end else if (cnt_q == TIMEOUT) begin
                  state_q   <= ERROR;
                  stalled_q <= 1'b0;
                  valid_q   <= 1'b0;
                  err_q     <= 1'b1;
               end else if (cnt_q != 8'hFF) begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign pc_o          = pc_q;
   assign pc_valid_o    = valid_q;
   assign stalled_o     = stalled_q;
   assign timeout_err_o = err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed vectors with hand-computed expectations for pc_sequencer
module tb_pc_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_busy, dmem_busy, jump, branch, zero;
   logic [7:0]  offset;
   logic [31:0] pc;
   logic        pc_valid, stalled, timeout_err;
   int          vectors = 0;
   int          miscompares = 0;

   always #5 clk = ~clk;

   pc_sequencer #(.RESET_PC(32'h0), .OFFSET_W(8), .STALL_TIMEOUT(5)) dut (
      .clk_i           (clk),
      .rst_ni          (rst_n),
      .imem_busywait_i (imem_busy),
      .dmem_busywait_i (dmem_busy),
      .jump_i          (jump),
      .branch_i        (branch),
      .zero_i          (zero),
      .offset_i        (offset),
      .pc_o            (pc),
      .pc_valid_o      (pc_valid),
      .stalled_o       (stalled),
      .timeout_err_o   (timeout_err)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [31:0] e_pc, input logic e_v, input logic e_s, input logic e_e);
      chk32({tag, ".pc"}, pc, e_pc);
      chk1({tag, ".valid"}, pc_valid, e_v);
      chk1({tag, ".stalled"}, stalled, e_s);
      chk1({tag, ".err"}, timeout_err, e_e);
   endtask

   initial begin
      rst_n = 1'b0; imem_busy = 1'b0; dmem_busy = 1'b0;
      jump = 1'b0; branch = 1'b0; zero = 1'b0; offset = 8'h00;
      #12;
      chk_all("reset", 32'h0, 1'b0, 1'b0, 1'b0);
      rst_n = 1'b1;
      step(); chk_all("sync_edge", 32'h0, 1'b0, 1'b0, 1'b0);
      step(); chk_all("first_fetch", 32'h0, 1'b1, 1'b0, 1'b0);
      step(); chk32("seq4", pc, 32'h4);
      step(); chk32("seq8", pc, 32'h8);
      step(); chk32("seq12", pc, 32'hC);
      step(); chk32("seq16", pc, 32'h10);
      branch = 1'b1; zero = 1'b1; offset = 8'hFE;
      step(); chk32("beq_taken", pc, 32'hC);
      branch = 1'b0; zero = 1'b0;
      step(); chk32("back_to_10", pc, 32'h10);
      branch = 1'b1; zero = 1'b0;
      step(); chk32("beq_not_taken", pc, 32'h14);
      branch = 1'b0; jump = 1'b1; offset = 8'hFE;
      step(); chk32("jump_back", pc, 32'h10);
      branch = 1'b1; zero = 1'b0; offset = 8'h03;
      step(); chk32("jump_over_branch", pc, 32'h20);
      branch = 1'b0; offset = 8'hF9;
      step(); chk32("jump_to_8", pc, 32'h8);
      imem_busy = 1'b1; jump = 1'b1; offset = 8'h02;
      for (int i = 0; i < 3; i++) begin
         step(); chk_all("imem_stall", 32'h8, 1'b1, 1'b1, 1'b0);
      end
      imem_busy = 1'b0;
      step(); chk_all("stall_release_jump", 32'h14, 1'b1, 1'b0, 1'b0);
      jump = 1'b1; offset = 8'hF9;
      step(); chk32("to_fffffffc", pc, 32'hFFFF_FFFC);
      jump = 1'b0;
      step(); chk32("wrap_seq", pc, 32'h0);
      jump = 1'b1; offset = 8'hFD;
      step(); chk32("to_fffffff8", pc, 32'hFFFF_FFF8);
      offset = 8'h01;
      step(); chk32("wrap_target", pc, 32'h0);
      offset = 8'h0F;
      step(); chk32("to_40", pc, 32'h40);
      jump = 1'b0; dmem_busy = 1'b1;
      step(); chk_all("dmem_stall1", 32'h40, 1'b1, 1'b1, 1'b0);
      step(); chk_all("dmem_stall2", 32'h40, 1'b1, 1'b1, 1'b0);
      #2 rst_n = 1'b0;
      #1 chk_all("async_reset", 32'h0, 1'b0, 1'b0, 1'b0);
      dmem_busy = 1'b0;
      #1 rst_n = 1'b1;
      step(); chk1("restart_sync.valid", pc_valid, 1'b0);
      step(); chk_all("restart_fetch", 32'h0, 1'b1, 1'b0, 1'b0);
      step(); chk32("restart_seq4", pc, 32'h4);
      dmem_busy = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step(); chk_all("timeout_stall", 32'h4, 1'b1, 1'b1, 1'b0);
      end
      step(); chk_all("timeout_error", 32'h4, 1'b0, 1'b0, 1'b1);
      dmem_busy = 1'b0; jump = 1'b1; offset = 8'h03;
      for (int i = 0; i < 3; i++) begin
         step(); chk_all("error_frozen", 32'h4, 1'b0, 1'b0, 1'b1);
      end
      #2 rst_n = 1'b0;
      #1 chk_all("error_reset", 32'h0, 1'b0, 1'b0, 1'b0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Registered program-counter controller for the single-cycle processor. It owns the PC register, selects the next PC from sequential increment, jump and branch targets, and freezes the PC while instruction or data memory signals busywait. A watchdog counter flags a memory stall that lasts too long. The block sits between the control unit/ALU (decision inputs) and the instruction memory (PC output), and replaces the free-running PC adder path.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- OFFSET_W, 8, width of the signed instruction-word offset field
- STALL_TIMEOUT, 255, consecutive stall cycles that trigger the error state (1..255)

- CLK  in  1  single system clock; all state updates on the rising edge
- RESET  in  1  asynchronous, active-low; asserting it immediately forces the reset state
- IMEM_BUSYWAIT  in  1  instruction memory not ready
- DMEM_BUSYWAIT  in  1  data memory not ready
- JUMP  in  1  unconditional jump for the current instruction
- BRANCH  in  1  beq-type instruction
- ZERO  in  1  ALU zero flag for the current instruction
- OFFSET  in  OFFSET_W  signed offset, in instructions, relative to PC+4
- PC  out  32  current instruction address
- PC_VALID  out  1  PC addresses a live instruction
- STALLED  out  1  sequencer is in STALL
- TIMEOUT_ERR  out  1  sticky stall-timeout error

## Operation
- States: IDLE, RUN, STALL, ERROR. Reset → IDLE.
- Reset values: PC=RESET_PC, PC_VALID=0, STALLED=0, TIMEOUT_ERR=0, stall count=0.
- IDLE: exactly one cycle, then RUN. PC stays RESET_PC. PC_VALID becomes 1 on entry to RUN.
- Let busy = IMEM_BUSYWAIT | DMEM_BUSYWAIT.
- RUN, busy=1: go to STALL. PC holds. Stall count becomes 1.
- RUN, busy=0: PC ← next_pc.
- next_pc priority:
  - JUMP=1 → target
  - BRANCH & ZERO → target
  - otherwise → PC+4
- target = PC + 4 + (sign_extend(OFFSET) << 2). All arithmetic is modulo 2^32. Wrap-around is legal: PC=32'hFFFF_FFFC with no branch → 0.
- STALL, busy=1: PC holds. Stall count increments. When the count reaches STALL_TIMEOUT → ERROR.
- STALL, busy=0: PC ← next_pc, evaluated on the current inputs. Go to RUN and clear the count.
  - The branch/jump decision is taken only on the release cycle.
  - Decision inputs sampled during busy cycles are ignored.
- ERROR: PC frozen, PC_VALID=0, TIMEOUT_ERR=1. Only RESET exits this state.
- Simultaneous events:
  - busy dominates JUMP/BRANCH in every state.
  - JUMP dominates BRANCH.
  - RESET dominates everything, including mid-stall and ERROR.
- STALLED = (state==STALL).

## Timing
- PC, PC_VALID, STALLED and TIMEOUT_ERR are registered and change only on the CLK rising edge, or asynchronously on RESET assertion.
- Inputs are sampled on the rising edge. Their combinational paths end at the next-PC mux.
- Latency:
  - Decision to PC update: 1 cycle.
  - Busywait assert to STALLED=1: 1 cycle.
  - Busywait release to PC advance: 1 cycle (same edge as return to RUN).
- First valid fetch: PC=RESET_PC with PC_VALID=1 on the second rising edge after RESET deasserts.
- Timeout: ERROR is entered on the edge where the stall count equals STALL_TIMEOUT.
- RESET release is synchronised internally with a 2-flop deassertion synchroniser; the first edge after release is consumed by that synchroniser.

## Structure
- Shared package pc_seq_pkg:
  - state enum (IDLE, RUN, STALL, ERROR)
  - PC_INCR=4
  - DEFAULT_STALL_TIMEOUT=255
- Sub-module pc_target_calc: combinational. Takes PC, OFFSET, JUMP, BRANCH, ZERO; returns next_pc. It is reused by the verification reference model.
- Stall counter is 8 bits, saturating, inside pc_sequencer.

## Test plan
- Reset then run, no busy, no branches → PC sequence 0, 4, 8, 12; PC_VALID rises with PC=0.
- At PC=0x10: BRANCH=1, ZERO=1, OFFSET=8'hFE → next PC=0x0C. Same with ZERO=0 → 0x14. JUMP=1 with BRANCH=1, OFFSET=8'h03 → 0x20.
- At PC=0x08: IMEM_BUSYWAIT high 3 cycles with JUMP=1, OFFSET=2 → STALLED for 3 cycles, PC held at 0x08, then PC=0x14.
- PC=32'hFFFF_FFFC, no branch → PC=0. OFFSET=8'h01 at PC=32'hFFFF_FFF8 → PC=0.
- DMEM_BUSYWAIT stuck high with STALL_TIMEOUT=5 → ERROR after 5 stall cycles, TIMEOUT_ERR=1, PC_VALID=0. Input changes are ignored until RESET.
- Assert RESET mid-stall at PC=0x40 → outputs return to reset values immediately without waiting for CLK; the run restarts from RESET_PC.
